vload_unit: RTL

- Load-side producer for one lane's VRF write-back port; drives the lane's load_op_valid/load_op_gnt interface (WB_VLU slot of vrf_accesser).
- Accepts one load instruction descriptor at a time and receives memory response beats, one VRF word per beat.
- Converts each beat into a VRF write with address and tail strobe, buffers it, and signals completion with the instruction id.

---
 rtl/vload_unit_pkg.sv | 51 +++++
 rtl/vload_unit_wbuf.sv | 62 ++++++
 rtl/vload_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vload_unit_pkg.sv
// Shared types for the vector load unit: VRF word/strobe/address/id types,
// the load descriptor, the write-buffer entry, the FSM state and a tail
// strobe helper.
`timescale 1ns/1ps
package vload_unit_pkg;

  localparam int unsigned VLENB    = 16;
  localparam int unsigned VrfDataW = 64;
  localparam int unsigned VrfAddrW = 8;
  localparam int unsigned InsnIdW  = 4;
  localparam int          StrbW    = VrfDataW / 8;
  localparam int unsigned TailW    = $clog2(VrfDataW / 8);

  typedef logic [VrfDataW-1:0] vrf_data_t;
  typedef logic [StrbW-1:0]    vrf_strb_t;
  typedef logic [VrfAddrW-1:0] vrf_addr_t;
  typedef logic [InsnIdW-1:0]  insn_id_t;

  // Byte length of one load; wide enough for a full LMUL=8 register group.
  localparam int unsigned VluLenW = $clog2(8 * VLENB + 1);
  typedef logic [VluLenW-1:0] vlu_len_t;

  typedef struct packed {
    vrf_addr_t vd_addr;
    vlu_len_t  len;
    insn_id_t  id;
  } vlu_req_t;

  typedef struct packed {
    vrf_data_t data;
    vrf_strb_t strb;
    vrf_addr_t addr;
  } vlu_wentry_t;

  typedef enum logic [1:0] {
    VLU_IDLE  = 2'd0,
    VLU_RECV  = 2'd1,
    VLU_DRAIN = 2'd2,
    VLU_DONE  = 2'd3
  } vlu_state_e;

  // Low 'tail' bytes enabled; tail==0 means the word is fully valid.
  function automatic vrf_strb_t tail_strb(input logic [TailW-1:0] tail);
    vrf_strb_t s;
    for (int i = 0; i < StrbW; i++) begin
      s[i] = (tail == '0) || (i < int'(tail));
    end
    return s;
  endfunction

endpackage

// File: rtl/vload_unit_wbuf.sv
// vlu_wbuf: small synchronous FIFO of VRF write entries between the memory
// response side and the lane write port. The head is read straight out of
// the entry registers, so a word pushed in one cycle is visible at the
// head in the next. Push is ignored when full, pop is ignored when empty.
`timescale 1ns/1ps
module vlu_wbuf
  import vload_unit_pkg::*;
#(
  parameter int unsigned BufDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  vlu_wentry_t push_data_i,
  input  logic        pop_i,
  output vlu_wentry_t head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        last_o
);

  localparam int unsigned PtrW = $clog2(BufDepth);
  localparam int unsigned CntW = PtrW + 1;

  vlu_wentry_t     mem_q [BufDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(BufDepth));
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CntW'(1));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Entry storage, pointers (wrap naturally, depth is a power of two) and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BufDepth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vload_unit.sv
// vload_unit: load-side producer for one lane's VRF write-back port.
// Takes one load descriptor at a time, turns each memory response beat into
// a VRF word write (address + tail strobe), buffers it in vlu_wbuf and
// pulses load_done_o with the instruction id once every word is granted.
//
// Handshakes: req_*, mem_* transfer on a cycle where valid && ready are both
// high; valid never depends on ready. On the lane side load_op_valid_o stays
// high with load_op_* held stable until load_op_gnt_i, and an entry is
// retired on valid && gnt. mem_ready_o depends only on registered state, so
// a full buffer stalls the memory side even if it drains that same cycle.
//
// Optional feature: define VLU_STALL_CNT_EN to add stall_cnt_o, a saturating
// count of cycles with load_op_valid_o && !load_op_gnt_i.
`timescale 1ns/1ps
module vload_unit
  import vload_unit_pkg::*;
#(
  parameter int unsigned BufDepth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      req_valid_i,
  output logic      req_ready_o,
  input  vlu_req_t  req_i,
  input  logic      mem_valid_i,
  output logic      mem_ready_o,
  input  vrf_data_t mem_data_i,
  output logic      load_op_valid_o,
  input  logic      load_op_gnt_i,
  output vrf_data_t load_op_o,
  output vrf_strb_t load_op_strb_o,
  output vrf_addr_t load_op_addr_o,
  output insn_id_t  load_id_o,
  output logic      load_done_o,
`ifdef VLU_STALL_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  output insn_id_t  load_done_id_o
);

  localparam int unsigned WordB  = $bits(vrf_data_t) / 8;
  localparam int unsigned WordSh = $clog2(WordB);

  vlu_state_e           state_q, state_d;
  vrf_addr_t            addr_q, addr_d;
  insn_id_t             id_q, id_d;
  vlu_len_t             words_q, words_d;
  logic [TailW-1:0]     tail_q, tail_d;

  logic                 req_hs, beat, pop;
  logic                 fifo_full, fifo_empty, fifo_last;
  vlu_wentry_t          push_entry, head;
  logic [VluLenW:0]     len_round;
  vlu_len_t             words_new;

  assign req_hs = req_valid_i && req_ready_o;
  assign beat   = mem_valid_i && mem_ready_o;
  assign pop    = load_op_valid_o && load_op_gnt_i;

  // Word count rounded up: ceil(len / WordB).
  assign len_round = {1'b0, req_i.len} + (VluLenW + 1)'(WordB - 1);
  assign words_new = vlu_len_t'(len_round >> WordSh);

  assign push_entry.data = mem_data_i;
  assign push_entry.strb = (words_q == vlu_len_t'(1)) ? tail_strb(tail_q) : '1;
  assign push_entry.addr = addr_q;

  vlu_wbuf #(
    .BufDepth (BufDepth)
  ) u_wbuf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (beat),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .last_o      (fifo_last)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= VLU_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: DRAIN leaves on the cycle the last buffered word is granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      VLU_IDLE: begin
        if (req_hs) state_d = (req_i.len == '0) ? VLU_DONE : VLU_RECV;
      end
      VLU_RECV: begin
        if (beat && (words_q == vlu_len_t'(1))) state_d = VLU_DRAIN;
      end
      VLU_DRAIN: begin
        if (fifo_empty || (fifo_last && pop)) state_d = VLU_DONE;
      end
      VLU_DONE: state_d = VLU_IDLE;
      default:  state_d = VLU_IDLE;
    endcase
  end

  // FSM outputs: request/beat acceptance and the completion pulse.
  always_comb begin
    req_ready_o    = rst_ni && (state_q == VLU_IDLE);
    mem_ready_o    = (state_q == VLU_RECV) && !fifo_full;
    load_done_o    = (state_q == VLU_DONE);
    load_done_id_o = (state_q == VLU_DONE) ? id_q : '0;
  end

  // Descriptor bookkeeping: latch on accept, advance address/count per beat.
  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    words_d = words_q;
    tail_d  = tail_q;
    if (req_hs) begin
      addr_d  = req_i.vd_addr;
      id_d    = req_i.id;
      words_d = words_new;
      tail_d  = req_i.len[TailW-1:0];
    end else if (beat) begin
      addr_d  = addr_q + vrf_addr_t'(1);
      words_d = words_q - vlu_len_t'(1);
    end
  end

  // Descriptor registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      id_q    <= '0;
      words_q <= '0;
      tail_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      id_q    <= id_d;
      words_q <= words_d;
      tail_q  <= tail_d;
    end
  end

  // Lane port driven from the buffer head; zeroed whenever nothing is pending.
  always_comb begin
    load_op_valid_o = !fifo_empty;
    load_op_o       = fifo_empty ? '0 : head.data;
    load_op_strb_o  = fifo_empty ? '0 : head.strb;
    load_op_addr_o  = fifo_empty ? '0 : head.addr;
    load_id_o       = fifo_empty ? '0 : id_q;
  end

`ifdef VLU_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles the lane refused a pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (load_op_valid_o && !load_op_gnt_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
